tdm_demux_1x8: RTL and testbench

Time-division 1-to-8 demultiplexer. It is the receive end of an 8:1 mux serial link. The transmitter walks a 3-bit select {s2,s1,s0} from 0 to 7 and sends input I[k] in slot k. This block takes that framed serial stream, steers slot k into lane k of a shadow register, and presents the reassembled 8-lane word with a one-cycle valid pulse. It sits at the far end of any serialized mux link in the design.

---
 rtl/tdm_demux_1x8.sv | 139 +++++++++++++
 tb/tb_tdm_demux_1x8.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1x8.sv
// Receive end of an 8:1 TDM serial link: steers slot k of each framed stream
// into lane k and publishes the reassembled 8-lane word with a valid pulse.
module tdm_demux_1x8 #(
  parameter int unsigned DW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   din,
  input  logic            din_valid,
  input  logic            frame_start,
  output logic [8*DW-1:0] dout,
  output logic            dout_valid,
  output logic            frame_err,
  output logic [2:0]      slot,
  output logic            busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  state_e          state_r;
  state_e          state_nxt_s;
  logic [2:0]      slot_r;
  logic [2:0]      slot_nxt_s;
  logic [7*DW-1:0] shadow_r;
  logic [7*DW-1:0] shadow_nxt_s;
  logic [8*DW-1:0] dout_r;
  logic [8*DW-1:0] dout_nxt_s;
  logic            dout_valid_r;
  logic            dout_valid_nxt_s;
  logic            frame_err_r;
  logic            frame_err_nxt_s;
  logic            busy_r;
  logic            start_s;
  logic            cont_s;
  logic            last_s;

  // Beat qualification: frame_start only counts on a valid beat.
  assign start_s = din_valid & frame_start;
  assign cont_s  = din_valid & ~frame_start;
  assign last_s  = (slot_r == 3'd7);

  // State register plus all registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      slot_r       <= 3'd0;
      shadow_r     <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      slot_r       <= slot_nxt_s;
      shadow_r     <= shadow_nxt_s;
      dout_r       <= dout_nxt_s;
      dout_valid_r <= dout_valid_nxt_s;
      frame_err_r  <= frame_err_nxt_s;
      busy_r       <= (state_nxt_s == ST_RECV);
    end
  end

  // Next-state logic: a restart keeps us in RECV, only completion leaves it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_RECV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (cont_s && last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath and pulse outputs; dout only moves when slot 7 completes a frame.
  always_comb begin
    slot_nxt_s       = slot_r;
    shadow_nxt_s     = shadow_r;
    dout_nxt_s       = dout_r;
    dout_valid_nxt_s = 1'b0;
    frame_err_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          shadow_nxt_s[DW-1:0] = din;
          slot_nxt_s           = 3'd1;
        end else begin
          slot_nxt_s = 3'd0;
        end
      end
      ST_RECV: begin
        if (start_s) begin
          frame_err_nxt_s      = 1'b1;
          shadow_nxt_s[DW-1:0] = din;
          slot_nxt_s           = 3'd1;
        end else if (cont_s && last_s) begin
          dout_nxt_s       = {din, shadow_r};
          dout_valid_nxt_s = 1'b1;
          slot_nxt_s       = 3'd0;
        end else if (cont_s) begin
          for (int k = 0; k < 7; k++) begin
            if (slot_r == 3'(k)) begin
              shadow_nxt_s[k*DW +: DW] = din;
            end else begin
              shadow_nxt_s[k*DW +: DW] = shadow_r[k*DW +: DW];
            end
          end
          slot_nxt_s = slot_r + 3'd1;
        end else begin
          slot_nxt_s = slot_r;
        end
      end
      default: begin
        slot_nxt_s   = 3'd0;
        shadow_nxt_s = '0;
      end
    endcase
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign frame_err  = frame_err_r;
  assign slot       = slot_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed and randomized checks of tdm_demux_1x8 against a frame-level
// reference model built from arrays of received lanes.
module tb_tdm_demux_1x8;

  localparam int DW = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   din = '0;
  logic            din_valid = 1'b0;
  logic            frame_start = 1'b0;
  logic [8*DW-1:0] dout;
  logic            dout_valid;
  logic            frame_err;
  logic [2:0]      slot;
  logic            busy;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  int              m_slot;
  bit              m_busy;
  logic [DW-1:0]   m_lane [8];
  logic [8*DW-1:0] m_dout;
  bit              m_dv;
  bit              m_fe;
  int              dv_count;
  int              fe_count;

  tdm_demux_1x8 #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .dout(dout), .dout_valid(dout_valid),
    .frame_err(frame_err), .slot(slot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot = 0; m_busy = 0; m_dout = '0; m_dv = 0; m_fe = 0;
    for (int i = 0; i < 8; i++) m_lane[i] = '0;
  endtask

  task automatic model_step(input logic v, input logic fs, input logic [DW-1:0] d);
    m_dv = 0; m_fe = 0;
    if (v) begin
      if (fs) begin
        if (m_busy) m_fe = 1;
        m_lane[0] = d; m_slot = 1; m_busy = 1;
      end else if (m_busy) begin
        m_lane[m_slot] = d;
        if (m_slot == 7) begin
          for (int i = 0; i < 8; i++) m_dout[i*DW +: DW] = m_lane[i];
          m_dv = 1; m_slot = 0; m_busy = 0;
        end else begin
          m_slot++;
        end
      end
    end
  endtask

  task automatic check_all();
    check("dout", 64'(dout), 64'(m_dout));
    check("dout_valid", 64'(dout_valid), 64'(m_dv));
    check("frame_err", 64'(frame_err), 64'(m_fe));
    check("slot", 64'(slot), 64'(m_slot));
    check("busy", 64'(busy), 64'(m_busy));
    check("dv_fe_exclusive", 64'(dout_valid & frame_err), 64'(0));
    if (dout_valid) dv_count++;
    if (frame_err) fe_count++;
  endtask

  task automatic beat(input logic v, input logic fs, input logic [DW-1:0] d);
    din_valid = v; frame_start = fs; din = d;
    model_step(v, fs, d);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic send_frame(input logic [7:0] val);
    for (int k = 0; k < 8; k++) beat(1'b1, (k == 0), val[k]);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    // reset with random inputs
    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'($urandom_range(0, 1)); frame_start = 1'($urandom_range(0, 1));
      din = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_all();
    end
    rst_n = 1'b1;
    beat(1'b0, 1'b0, 1'b0);

    // single frame 1,0,1,1,0,0,1,0
    dv_count = 0;
    send_frame(8'b01001101);
    check("single_dout", 64'(dout), 64'h4D);
    check("single_dv_count", 64'(dv_count), 64'd1);
    beat(1'b0, 1'b0, 1'b0);
    check("single_dv_once", 64'(dout_valid), 64'd0);

    // same frame with stalls before slot 3 and slot 7
    dv_count = 0;
    beat(1'b1, 1'b1, 1'b1); beat(1'b1, 1'b0, 1'b0); beat(1'b1, 1'b0, 1'b1);
    stall(3);
    check("stall_slot3", 64'(slot), 64'd3);
    beat(1'b1, 1'b0, 1'b1); beat(1'b1, 1'b0, 1'b0); beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    stall(5);
    check("stall_slot7", 64'(slot), 64'd7);
    beat(1'b1, 1'b0, 1'b0);
    check("stall_dout", 64'(dout), 64'h4D);
    check("stall_dv_count", 64'(dv_count), 64'd1);

    // early restart: 5 slots of ones, then an all-zero frame
    dv_count = 0; fe_count = 0;
    for (int k = 0; k < 5; k++) beat(1'b1, (k == 0), 1'b1);
    send_frame(8'h00);
    check("restart_fe_count", 64'(fe_count), 64'd1);
    check("restart_dv_count", 64'(dv_count), 64'd1);
    check("restart_dout", 64'(dout), 64'h00);

    // back-to-back full-rate frames
    dv_count = 0; fe_count = 0;
    send_frame(8'hA5);
    check("b2b_first", 64'(dout), 64'hA5);
    check("b2b_first_dv", 64'(dout_valid), 64'd1);
    send_frame(8'h3C);
    check("b2b_second", 64'(dout), 64'h3C);
    check("b2b_second_dv", 64'(dout_valid), 64'd1);
    check("b2b_dv_count", 64'(dv_count), 64'd2);
    check("b2b_fe_count", 64'(fe_count), 64'd0);

    // idle garbage, then mid-frame reset
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    check("idle_slot", 64'(slot), 64'd0);
    check("idle_dout", 64'(dout), 64'h3C);
    for (int k = 0; k < 5; k++) beat(1'b1, (k == 0), 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_dout", 64'(dout), 64'h00);
    check("midrst_slot", 64'(slot), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(8'h81);
    check("after_rst_dout", 64'(dout), 64'h81);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      beat(1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 99) < 12),
           1'($urandom_range(0, 1)));
    end
    // random full frames to make sure completions are exercised
    for (int i = 0; i < 10; i++) send_frame(8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
